// File: rtl/tx_frame_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tx_frame_mux
//  Brief    : Four-source, fixed-priority TX frame formatter. Serves one
//             16-bit word from the highest-priority requester as a 3-byte
//             frame (header, data MSB, data LSB) into a TX FIFO write port.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_frame_mux #(
    parameter logic [7:0] HEADER_BASE = 8'hA0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] in_0,
    input  logic [15:0] in_1,
    input  logic [15:0] in_2,
    input  logic [15:0] in_3,
    input  logic        wfull,
    output logic [7:0]  out,
    output logic        winc,
    output logic [3:0]  accept
);

    // Header upper bits; the two low bits always carry the channel number,
    // so any stray low bits in HEADER_BASE are ignored rather than OR-ed in.
    localparam logic [5:0] c_HDR_HI = HEADER_BASE[7:2];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_MSB  = 2'd2,
        S_LSB  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ch;
    logic [15:0] r_data;
    logic [3:0]  r_accept;

    logic        w_any;
    logic [1:0]  w_ch;
    logic [15:0] w_data;
    logic [3:0]  w_onehot;
    logic        w_winc;
    logic [7:0]  w_out;

    // Fixed-priority pick: lowest requesting index wins.
    always_comb begin
        w_any = |req;
        w_ch  = 2'd0;
        if (req[0])      w_ch = 2'd0;
        else if (req[1]) w_ch = 2'd1;
        else if (req[2]) w_ch = 2'd2;
        else if (req[3]) w_ch = 2'd3;
    end

    // Data word and one-hot acknowledge for the winning source.
    always_comb begin
        w_onehot = 4'b0001 << w_ch;
        case (w_ch)
            2'd0:    w_data = in_0;
            2'd1:    w_data = in_1;
            2'd2:    w_data = in_2;
            default: w_data = in_3;
        endcase
    end

    // A byte is written whenever a frame is in flight and the FIFO has room.
    assign w_winc = (r_state != S_IDLE) && !wfull;

    // Byte presented to the FIFO, decoded from the registered frame state;
    // it holds its value across stalls because the state does not move.
    always_comb begin
        case (r_state)
            S_HDR:   w_out = {c_HDR_HI, r_ch};
            S_MSB:   w_out = r_data[15:8];
            S_LSB:   w_out = r_data[7:0];
            default: w_out = 8'h00;
        endcase
    end

    // Frame sequencer: grant in IDLE, then step one byte per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ch     <= 2'd0;
            r_data   <= 16'h0000;
            r_accept <= 4'b0000;
        end else begin
            r_accept <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch     <= w_ch;
                        r_data   <= w_data;
                        r_accept <= w_onehot;
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_winc) r_state <= S_MSB;
                end
                S_MSB: begin
                    if (w_winc) r_state <= S_LSB;
                end
                S_LSB: begin
                    if (w_winc) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out    = w_out;
    assign winc   = w_winc;
    assign accept = r_accept;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_frame_mux
//  Brief    : Directed self-checking bench for tx_frame_mux. A FIFO model
//             logs every byte written; frames are compared against
//             hand-computed byte sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_mux;

    typedef logic [7:0] byte_q_t [$];

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] in_0, in_1, in_2, in_3;
    logic        wfull;
    logic [7:0]  out;
    logic        winc;
    logic [3:0]  accept;

    int checks = 0;
    int errors = 0;

    byte_q_t log_q;
    int      acc_cnt [4];
    int      acc_base [4];
    byte_q_t exp_q;
    int      base;

    tx_frame_mux #(.HEADER_BASE(8'hA0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .in_0   (in_0),
        .in_1   (in_1),
        .in_2   (in_2),
        .in_3   (in_3),
        .wfull  (wfull),
        .out    (out),
        .winc   (winc),
        .accept (accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
    end

    // FIFO model: captures out on every rising edge where winc is high.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && winc === 1'b1) log_q.push_back(out);
        for (int i = 0; i < 4; i++)
            if (accept[i] === 1'b1) acc_cnt[i] = acc_cnt[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int from, input byte_q_t exp);
        int n;
        n = log_q.size() - from;
        check({tag, "_count"}, n, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (from + i < log_q.size())
                check($sformatf("%s_byte%0d", tag, i), log_q[from + i], exp[i]);
            else
                check($sformatf("%s_byte%0d", tag, i), 32'hXXXX_XXXX, exp[i]);
        end
    endtask

    // Advance n cycles; like a well-behaved source, drop req on accept.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req = req & ~accept;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        wfull = 1'b0;
        in_0  = 16'h0000;
        in_1  = 16'h0000;
        in_2  = 16'h0000;
        in_3  = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out",    out,    8'h00);
        check("rst_winc",   winc,   1'b0);
        check("rst_accept", accept, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Single source 2 frame
        base = log_q.size();
        in_2 = 16'h5678;
        req  = 4'b0100;
        cyc(1);
        check("t1_accept", accept, 4'b0100);
        check("t1_hdr",    out,    8'hA2);
        check("t1_winc",   winc,   1'b1);
        cyc(1);
        check("t1_accept_off", accept, 4'b0000);
        check("t1_msb",    out,    8'h56);
        cyc(1);
        check("t1_lsb",    out,    8'h78);
        cyc(1);
        check("t1_idle_winc", winc, 1'b0);
        check("t1_idle_out",  out,  8'h00);
        exp_q = '{8'hA2, 8'h56, 8'h78};
        check_log("t1", base, exp_q);

        // All four request at once: strict priority order
        base = log_q.size();
        for (int i = 0; i < 4; i++) acc_base[i] = acc_cnt[i];
        in_0 = 16'h1234;
        in_1 = 16'hABCD;
        in_2 = 16'h5678;
        in_3 = 16'h1111;
        req  = 4'b1111;
        cyc(24);
        exp_q = '{8'hA0, 8'h12, 8'h34, 8'hA1, 8'hAB, 8'hCD,
                  8'hA2, 8'h56, 8'h78, 8'hA3, 8'h11, 8'h11};
        check_log("t2", base, exp_q);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_accept_cnt%0d", i), acc_cnt[i] - acc_base[i], 1);

        // Back-pressure: FIFO full for five cycles after the grant
        base  = log_q.size();
        in_0  = 16'hBEEF;
        req   = 4'b0001;
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check($sformatf("t3_stall_winc%0d", k), winc, 1'b0);
            check($sformatf("t3_stall_out%0d", k),  out,  8'hA0);
        end
        wfull = 1'b0;
        cyc(5);
        exp_q = '{8'hA0, 8'hBE, 8'hEF};
        check_log("t3", base, exp_q);

        // wfull toggling every cycle mid-frame
        base  = log_q.size();
        in_3  = 16'hC3C3;
        req   = 4'b1000;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            wfull = ~wfull;
        end
        wfull = 1'b0;
        cyc(4);
        exp_q = '{8'hA3, 8'hC3, 8'hC3};
        check_log("t4", base, exp_q);

        // Source data changes after the grant must not leak into the frame
        base = log_q.size();
        in_1 = 16'hABCD;
        req  = 4'b0010;
        cyc(1);
        check("t5_accept", accept, 4'b0010);
        in_1 = 16'h0000;
        cyc(5);
        exp_q = '{8'hA1, 8'hAB, 8'hCD};
        check_log("t5", base, exp_q);

        // Reset asserted while in MSB aborts the frame at once
        base = log_q.size();
        in_0 = 16'h1357;
        req  = 4'b0001;
        cyc(1);
        check("t6_hdr", out, 8'hA0);
        cyc(1);
        check("t6_msb", out, 8'h13);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out",    out,    8'h00);
        check("t6_rst_winc",   winc,   1'b0);
        check("t6_rst_accept", accept, 4'b0000);
        req = 4'b0000;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        exp_q = '{8'hA0};
        check_log("t6", base, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
